// File: rtl/zero_stuff_upsampler_if.sv
// zero_stuff_upsampler_if: input and output ready/valid streams of the upsampler.
interface zero_stuff_upsampler_if #(parameter int WORD_SIZE = 16);
    logic [WORD_SIZE-1:0] data_in;
    logic                 valid_in;
    logic                 ready_out;
    logic [WORD_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 first_out;
    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, first_out
    );
    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, first_out
    );
endinterface

// File: rtl/zero_stuff_upsampler.sv
// zero_stuff_upsampler: emits each accepted sample followed by FACTOR-1 zeros.
// Define ZERO_STUFF_UPSAMPLER_HOLD_EN to repeat the sample instead (zero-order hold).
module zero_stuff_upsampler #(
    parameter int WORD_SIZE = 16,
    parameter int FACTOR    = 4
) (
    input logic clk,
    input logic arst_n,
    zero_stuff_upsampler_if.slave bus
);
    localparam int PW = FACTOR > 1 ? $clog2(FACTOR) : 1;
    localparam logic [PW-1:0] LAST = PW'(FACTOR - 1);
    if (FACTOR < 1) begin : g_bad_factor
        $error("zero_stuff_upsampler: FACTOR must be >= 1");
    end
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [WORD_SIZE-1:0] sample, sample_nxt;
    logic last, in_xfer, out_xfer;
    assign last     = phase == LAST;
    assign in_xfer  = bus.valid_in && bus.ready_out;
    assign out_xfer = bus.valid_out && bus.ready_in;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            phase  <= '0;
            sample <= '0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            sample <= sample_nxt;
        end
    end
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        sample_nxt = in_xfer ? bus.data_in : sample;
        if (state == IDLE) begin
            if (in_xfer) begin
                state_nxt = EMIT;
                phase_nxt = '0;
            end
        end else if (out_xfer) begin
            phase_nxt = last ? '0 : phase + PW'(1);
            if (last && !in_xfer) state_nxt = IDLE;
        end
    end
    // A new sample can only enter as the final phase of the current one leaves.
    always_comb begin
        bus.ready_out = (state == IDLE) || (bus.ready_in && last);
        bus.valid_out = state == EMIT;
        bus.first_out = (state == EMIT) && (phase == '0);
`ifdef ZERO_STUFF_UPSAMPLER_HOLD_EN
        bus.data_out  = sample;
`else
        bus.data_out  = (phase == '0) ? sample : '0;
`endif
    end
endmodule

// File: tb/tb_zero_stuff_upsampler.sv
// tb_zero_stuff_upsampler: table vectors, directed corner sequences and random traffic
// checked against an output-queue model, on FACTOR=4 and FACTOR=1 instances.
module tb_zero_stuff_upsampler;
`ifdef ZERO_STUFF_UPSAMPLER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    typedef struct {
        logic [15:0] data;
        logic        first;
    } exp_t;
    typedef struct {
        logic        vi;
        logic [15:0] di;
        logic        ri;
        logic        ev;
        logic [15:0] ed;
        logic        ef;
        logic        er;
    } vec_t;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    logic vin[2], rin[2], vo[2], rdo[2], fo[2];
    logic [15:0] din[2], dout[2];
    int fac[2] = '{4, 1};
    exp_t q[2][$];
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    zero_stuff_upsampler_if #(.WORD_SIZE(16)) if4 ();
    zero_stuff_upsampler_if #(.WORD_SIZE(16)) if1 ();
    zero_stuff_upsampler #(.WORD_SIZE(16), .FACTOR(4)) u4 (.clk(clk), .arst_n(arst_n), .bus(if4.slave));
    zero_stuff_upsampler #(.WORD_SIZE(16), .FACTOR(1)) u1 (.clk(clk), .arst_n(arst_n), .bus(if1.slave));

    assign if4.valid_in = vin[0];
    assign if4.data_in  = din[0];
    assign if4.ready_in = rin[0];
    assign if1.valid_in = vin[1];
    assign if1.data_in  = din[1];
    assign if1.ready_in = rin[1];
    assign vo[0] = if4.valid_out;
    assign rdo[0] = if4.ready_out;
    assign fo[0] = if4.first_out;
    assign dout[0] = if4.data_out;
    assign vo[1] = if1.valid_out;
    assign rdo[1] = if1.ready_out;
    assign fo[1] = if1.first_out;
    assign dout[1] = if1.data_out;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle on instance d: drive, check before the edge, then advance the model.
    task automatic cyc(input int d, input logic vi, input logic [15:0] di, input logic ri,
                       input vec_t v, input bit use_v, output bit inx, output bit outx);
        vin[d] = vi;
        din[d] = di;
        rin[d] = ri;
        #1;
        check($sformatf("valid[%0d]", d), vo[d], q[d].size() != 0);
        check($sformatf("ready[%0d]", d), rdo[d], q[d].size() == 0 || (ri && q[d].size() == 1));
        if (q[d].size() != 0) begin
            check($sformatf("data[%0d]", d), dout[d], q[d][0].data);
            check($sformatf("first[%0d]", d), fo[d], q[d][0].first);
        end
        if (use_v) begin
            check("tab_valid", vo[d], v.ev);
            check("tab_ready", rdo[d], v.er);
            if (v.ev) begin
                check("tab_data", dout[d], v.ed);
                check("tab_first", fo[d], v.ef);
            end
        end
        inx  = vi && rdo[d];
        outx = vo[d] && ri;
        @(posedge clk);
        if (outx && q[d].size() != 0) void'(q[d].pop_front());
        if (inx)
            for (int k = 0; k < fac[d]; k++)
                q[d].push_back('{data: (k == 0 || HOLD) ? di : 16'h0, first: k == 0});
        @(negedge clk);
    endtask

    task automatic step(input int d, input logic vi, input logic [15:0] di, input logic ri,
                        output bit inx, output bit outx);
        vec_t nv;
        nv = '{default: '0};
        cyc(d, vi, di, ri, nv, 1'b0, inx, outx);
    endtask

    // Asserted between edges; outputs must clear without any clock edge.
    task automatic async_reset();
        #2 arst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid[%0d]", d), vo[d], 1'b0);
            check($sformatf("rst_data[%0d]", d), dout[d], 16'h0);
            check($sformatf("rst_first[%0d]", d), fo[d], 1'b0);
            check($sformatf("rst_ready[%0d]", d), rdo[d], 1'b1);
            q[d].delete();
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic drain(input int d, input string nm);
        bit a, x;
        int n = 0;
        while (q[d].size() != 0 && n < 50) begin
            step(d, 1'b0, 16'h0, 1'b1, a, x);
            n++;
        end
        check(nm, q[d].size(), 0);
    endtask

    initial begin
        vec_t tab[6];
        logic [15:0] z;
        logic [15:0] seq3[3];
        bit a, x;
        int n, nx;
        z = HOLD ? 16'h1234 : 16'h0;
        tab[0] = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1};
        tab[1] = '{1'b0, 16'h0,    1'b1, 1'b1, 16'h1234, 1'b1, 1'b0};
        tab[2] = '{1'b0, 16'h0,    1'b1, 1'b1, z,        1'b0, 1'b0};
        tab[3] = '{1'b0, 16'h0,    1'b1, 1'b1, z,        1'b0, 1'b0};
        tab[4] = '{1'b0, 16'h0,    1'b1, 1'b1, z,        1'b0, 1'b1};
        tab[5] = '{1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, 1'b1};
        seq3 = '{16'd100, -16'sd200, 16'd300};
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b0;
            din[d] = 16'h0;
            rin[d] = 1'b1;
        end
        @(negedge clk);
        async_reset();

        for (int i = 0; i < 6; i++)
            cyc(0, tab[i].vi, tab[i].di, tab[i].ri, tab[i], 1'b1, a, x);

        // Three samples offered back to back: 12 outputs, no bubble.
        n = 0;
        for (int s = 0; s < 3; s++) begin
            a = 1'b0;
            while (!a && n < 40) begin
                step(0, 1'b1, seq3[s], 1'b1, a, x);
                n++;
            end
        end
        while (q[0].size() != 0 && n < 40) begin
            step(0, 1'b0, 16'h0, 1'b1, a, x);
            n++;
        end
        check("burst_cycles", n, 13);

        // Backpressure at phase 1 of -5.
        nx = 0;
        step(0, 1'b1, -16'sd5, 1'b1, a, x);
        step(0, 1'b0, 16'h0, 1'b1, a, x);
        nx += int'(x);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, 16'h7777, 1'b0, a, x);
            check("stall_data", dout[0], HOLD ? 16'hfffb : 16'h0);
            nx += int'(x);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 16'h0, 1'b1, a, x);
            nx += int'(x);
        end
        check("stall_xfers", nx, 4);
        check("stall_empty", q[0].size(), 0);

        // Reset at phase 2 of 77, then a clean burst of 9.
        step(0, 1'b1, 16'd77, 1'b1, a, x);
        step(0, 1'b0, 16'h0, 1'b1, a, x);
        step(0, 1'b0, 16'h0, 1'b1, a, x);
        async_reset();
        step(0, 1'b0, 16'h0, 1'b1, a, x);
        step(0, 1'b1, 16'd9, 1'b1, a, x);
        check("post_rst_accept", a, 1'b1);
        drain(0, "post_rst_drain");

        // FACTOR=1: extremes back to back.
        step(1, 1'b1, 16'h8000, 1'b1, a, x);
        step(1, 1'b1, 16'h7fff, 1'b1, a, x);
        check("f1_accept2", a, 1'b1);
        check("f1_data0", dout[1], 16'h7fff);
        step(1, 1'b0, 16'h0, 1'b1, a, x);
        drain(1, "f1_drain");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 400; i++)
                step(d, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0, a, x);
            drain(d, $sformatf("rand_drain[%0d]", d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
